gtp_upload: RTL and testbench

Streams a region of Galaksija RAM to the host as a GTP tape image over the data_io upload channel. It is the read-side counterpart of the TAPGTP download path. It sits between data_io's upload strobes and a spare read port of the core RAM. It prefetches each byte, wraps the memory dump in a GTP standard block with a Galaksija tape header and checksum, and reports completion.

---
 rtl/gtp_upload.sv | 181 ++++++++++++++++++
 tb/tb_gtp_upload.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtp_upload.sv
// Streams a Galaksija RAM region to the host as a GTP standard block over the data_io
// upload channel: 10-byte header, prefetched RAM bytes, then the tape checksum.
module gtp_upload #(
  parameter int unsigned ADDR_W  = 16,
  parameter logic [15:0] MAX_LEN = 16'hFFF9
) (
  input  logic              clk_sys,
  input  logic              reset_in,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_din,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StFetch,
    StWait,
    StData,
    StCsum,
    StEnd
  } state_e;

  state_e            state_q, state_d;
  logic              upload_q;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] endp_q, endp_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       didx_q, didx_d;
  logic [3:0]        hidx_q, hidx_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] span;
  logic [31:0]       span32;
  logic [15:0]       n_new;
  logic [15:0]       start16, endp16, pay_len;
  logic [15:0]       didx_inc;
  logic [7:0]        hdr_byte;
  logic              upload_rise, rd_ok, abort;

  assign upload_rise = ioctl_upload & ~upload_q;
  assign rd_ok       = ioctl_rd & ioctl_upload;
  assign abort       = ~ioctl_upload && (state_q != StIdle) && (state_q != StEnd);

  // Data length from the live inputs, clamped so the payload length stays within 16 bits.
  assign span   = (end_addr > start_addr) ? end_addr - start_addr : '0;
  assign span32 = 32'(span);
  assign n_new  = (span32 > 32'(MAX_LEN)) ? MAX_LEN : span32[15:0];

  assign start16  = 16'(start_q);
  assign endp16   = 16'(endp_q);
  assign pay_len  = len_q + 16'd6;
  assign didx_inc = didx_q + 16'd1;

  always_comb begin
    hdr_byte = 8'h00;
    case (hidx_q)
      4'd1:    hdr_byte = pay_len[7:0];
      4'd2:    hdr_byte = pay_len[15:8];
      4'd5:    hdr_byte = 8'hA5;
      4'd6:    hdr_byte = start16[7:0];
      4'd7:    hdr_byte = start16[15:8];
      4'd8:    hdr_byte = endp16[7:0];
      4'd9:    hdr_byte = endp16[15:8];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    endp_d  = endp_q;
    len_d   = len_q;
    didx_d  = didx_q;
    hidx_d  = hidx_q;
    sum_d   = sum_q;
    data_d  = data_q;
    done_d  = done_q;

    unique case (state_q)
      StIdle: begin
        if (upload_rise) begin
          start_d = start_addr;
          len_d   = n_new;
          endp_d  = start_addr + ADDR_W'(n_new);
          hidx_d  = 4'd0;
          didx_d  = 16'd0;
          sum_d   = 8'h00;
          done_d  = 1'b0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (rd_ok) begin
          // Only the four address bytes enter the checksum.
          if (hidx_q >= 4'd6) sum_d = sum_q + hdr_byte;
          if (hidx_q == 4'd9) begin
            state_d = (len_q != 16'd0) ? StFetch : StCsum;
          end else begin
            hidx_d = hidx_q + 4'd1;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        data_d  = mem_din;
        sum_d   = sum_q + mem_din;
        state_d = StData;
      end
      StData: begin
        if (rd_ok) begin
          didx_d  = didx_inc;
          state_d = (didx_inc < len_q) ? StFetch : StCsum;
        end
      end
      StCsum: begin
        if (rd_ok) begin
          done_d  = 1'b1;
          state_d = StEnd;
        end
      end
      StEnd: begin
        if (!ioctl_upload) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) state_d = StIdle;
  end

  always_comb begin
    ioctl_din = 8'h00;
    case (state_q)
      StHdr:   ioctl_din = hdr_byte;
      StData:  ioctl_din = data_q;
      StCsum:  ioctl_din = ~sum_q;
      default: ioctl_din = 8'h00;
    endcase
  end

  assign mem_rd   = (state_q == StFetch);
  assign mem_addr = mem_rd ? start_q + ADDR_W'(didx_q) : '0;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_in) begin
      state_q  <= StIdle;
      upload_q <= 1'b0;
      start_q  <= '0;
      endp_q   <= '0;
      len_q    <= 16'd0;
      didx_q   <= 16'd0;
      hidx_q   <= 4'd0;
      sum_q    <= 8'h00;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      upload_q <= ioctl_upload;
      start_q  <= start_d;
      endp_q   <= endp_d;
      len_q    <= len_d;
      didx_q   <= didx_d;
      hidx_q   <= hidx_d;
      sum_q    <= sum_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_gtp_upload.sv
// Directed bench for gtp_upload: fixed GTP streams compared byte by byte against
// hand-computed images, plus abort, reset and protocol-violation scenarios.
module tb_gtp_upload;

  logic        clk_sys = 1'b0;
  logic        reset_in;
  logic [15:0] start_addr, end_addr;
  logic        ioctl_upload, ioctl_rd;
  logic [7:0]  ioctl_din;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [0:65535];
  int         rd_pulses = 0;
  logic [15:0] last_addr = 16'h0000;

  logic [7:0] exp_basic [14] = '{8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3A, 8'h2C,
                                 8'h3D, 8'h2C, 8'h11, 8'h22, 8'h33, 8'hCA};
  logic [7:0] exp_empty [11] = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3A, 8'h2C,
                                 8'h3A, 8'h2C, 8'h33};
  logic [7:0] exp_wrap0 [11] = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hFE, 8'hFF,
                                 8'hFE, 8'hFF, 8'h05};
  logic [7:0] exp_wrap1 [12] = '{8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hFE, 8'hFF,
                                 8'hFF, 8'hFF, 8'h80, 8'h84};

  gtp_upload dut (
    .clk_sys      (clk_sys),
    .reset_in     (reset_in),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_din    (ioctl_din),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_din      (mem_din),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM read port: data valid the cycle after the strobe.
  always @(posedge clk_sys) begin
    if (mem_rd) begin
      mem_din   <= ram[mem_addr];
      rd_pulses <= rd_pulses + 1;
      last_addr <= mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_upload(input logic [15:0] s, input logic [15:0] e);
    start_addr   = s;
    end_addr     = e;
    ioctl_upload = 1'b1;
    tick();
  endtask

  task automatic stop_upload();
    ioctl_upload = 1'b0;
    tick();
    tick();
  endtask

  // Sample the current byte, consume it, then wait out the 4-cycle read spacing.
  task automatic read_byte(output logic [7:0] b);
    b        = ioctl_din;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    repeat (3) tick();
  endtask

  // Same as read_byte but with a stray extra pulse `gap` cycles later (gap 1 or 2).
  task automatic read_glitch(output logic [7:0] b, input int gap);
    b        = ioctl_din;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    repeat (gap - 1) tick();
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    repeat (3 - gap) tick();
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (ioctl_din !== 8'h00 || mem_addr !== 16'h0000 || mem_rd !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: din=%h addr=%h rd=%b busy=%b done=%b, want 00 0000 0 0 0",
               ioctl_din, mem_addr, mem_rd, busy, done);
    end
    reset_in = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] b;
    int base;
    base = rd_pulses;
    start_upload(16'h2C3A, 16'h2C3D);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic start: busy=%b done=%b, want 1 0", busy, done);
    end
    for (int i = 0; i < 14; i++) begin
      read_byte(b);
      n_checks++;
      if (b !== exp_basic[i]) begin
        n_fail++;
        $display("FAIL basic byte %0d: got %h want %h", i, b, exp_basic[i]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic end flags: done=%b busy=%b, want 1 1", done, busy);
    end
    read_byte(b);
    n_checks++;
    if (b !== 8'h00) begin
      n_fail++;
      $display("FAIL basic extra read: got %h want 00", b);
    end
    n_checks++;
    if (rd_pulses - base !== 3 || last_addr !== 16'h2C3C) begin
      n_fail++;
      $display("FAIL basic mem_rd: pulses=%0d last=%h, want 3 2C3C", rd_pulses - base, last_addr);
    end
    stop_upload();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic after close: busy=%b done=%b, want 0 1", busy, done);
    end
  endtask

  task automatic test_empty();
    logic [7:0]  b;
    logic [15:0] ends [2] = '{16'h2C3A, 16'h2000};
    int base;
    for (int k = 0; k < 2; k++) begin
      base = rd_pulses;
      start_upload(16'h2C3A, ends[k]);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL empty%0d done cleared: got %b want 0", k, done);
      end
      for (int i = 0; i < 11; i++) begin
        read_byte(b);
        n_checks++;
        if (b !== exp_empty[i]) begin
          n_fail++;
          $display("FAIL empty%0d byte %0d: got %h want %h", k, i, b, exp_empty[i]);
        end
      end
      n_checks++;
      if (rd_pulses != base || done !== 1'b1) begin
        n_fail++;
        $display("FAIL empty%0d end: pulses=%0d done=%b, want 0 1", k, rd_pulses - base, done);
      end
      stop_upload();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    start_upload(16'hFFFE, 16'h0001);
    for (int i = 0; i < 11; i++) begin
      read_byte(b);
      n_checks++;
      if (b !== exp_wrap0[i]) begin
        n_fail++;
        $display("FAIL wrap0 byte %0d: got %h want %h", i, b, exp_wrap0[i]);
      end
    end
    stop_upload();
    start_upload(16'hFFFE, 16'hFFFF);
    for (int i = 0; i < 12; i++) begin
      read_byte(b);
      n_checks++;
      if (b !== exp_wrap1[i]) begin
        n_fail++;
        $display("FAIL wrap1 byte %0d: got %h want %h", i, b, exp_wrap1[i]);
      end
    end
    n_checks++;
    if (last_addr !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL wrap1 fetch addr: got %h want FFFE", last_addr);
    end
    stop_upload();
  endtask

  task automatic test_abort();
    logic [7:0] b;
    start_upload(16'h2C3A, 16'h2C3D);
    for (int i = 0; i < 11; i++) read_byte(b);
    ioctl_upload = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ioctl_din !== 8'h00) begin
      n_fail++;
      $display("FAIL abort: busy=%b done=%b din=%h, want 0 0 00", busy, done, ioctl_din);
    end
    tick();
    start_upload(16'h2C3A, 16'h2C3D);
    n_checks++;
    if (busy !== 1'b1 || ioctl_din !== 8'h00) begin
      n_fail++;
      $display("FAIL abort restart: busy=%b din=%h, want 1 00", busy, ioctl_din);
    end
    for (int i = 0; i < 14; i++) begin
      read_byte(b);
      n_checks++;
      if (b !== exp_basic[i]) begin
        n_fail++;
        $display("FAIL abort restart byte %0d: got %h want %h", i, b, exp_basic[i]);
      end
    end
    stop_upload();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    start_upload(16'h2C3A, 16'h2C3D);
    for (int i = 0; i < 11; i++) read_byte(b);
    reset_in     = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    n_checks++;
    if (ioctl_din !== 8'h00 || mem_addr !== 16'h0000 || mem_rd !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset: din=%h addr=%h rd=%b busy=%b done=%b, want 00 0000 0 0 0",
               ioctl_din, mem_addr, mem_rd, busy, done);
    end
    reset_in = 1'b1;
    tick();
    start_upload(16'h2C3A, 16'h2C3D);
    for (int i = 0; i < 14; i++) begin
      read_byte(b);
      n_checks++;
      if (b !== exp_basic[i]) begin
        n_fail++;
        $display("FAIL post-reset byte %0d: got %h want %h", i, b, exp_basic[i]);
      end
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL post-reset done: got %b want 1", done);
    end
    stop_upload();
  endtask

  task automatic test_rd_violation();
    logic [7:0] b;
    int base;
    for (int gap = 1; gap <= 2; gap++) begin
      base = rd_pulses;
      start_upload(16'h2C3A, 16'h2C3D);
      for (int i = 0; i < 14; i++) begin
        // Reads of bytes 9..11 launch a fetch; their stray pulse lands in FETCH or WAIT.
        if (i >= 9 && i <= 11) read_glitch(b, gap);
        else read_byte(b);
        n_checks++;
        if (b !== exp_basic[i]) begin
          n_fail++;
          $display("FAIL rd violation gap%0d byte %0d: got %h want %h", gap, i, b, exp_basic[i]);
        end
      end
      n_checks++;
      if (rd_pulses - base !== 3 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL rd violation gap%0d end: pulses=%0d done=%b, want 3 1",
                 gap, rd_pulses - base, done);
      end
      stop_upload();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in     = 1'b0;
    start_addr   = 16'h0000;
    end_addr     = 16'h0000;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ram[16'h2C3A] = 8'h11;
    ram[16'h2C3B] = 8'h22;
    ram[16'h2C3C] = 8'h33;
    ram[16'hFFFE] = 8'h80;
    #1;
    test_reset();
    test_basic();
    test_empty();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_rd_violation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
